qc_var_z_cyclic_shifter: RTL and testbench
==========================================

Name: qc_var_z_cyclic_shifter

Overview:
- Multi-lane, pipelined cyclic shifter for QC-LDPC expansion. Each lane rotates a Z-bit sub-block by its own amount, within a run-time lifting size z ≤ MAXZ, in either direction.
- Adds valid/ready backpressure, a tag sideband and error flagging for illegal shift/z, none of which the fixed-width rotator has.
- Sits between the base-matrix sequencer and the parity/check-node datapath.

Parameters:
- MAXZ, 384, maximum lifting size; lane data width.
- NUM_LANES, 4, independent rotation lanes sharing z, direction and handshake.
- ROTATES_PER_CYCLE, 2, power-of-two shift levels per pipeline stage (≥1).
- TAG_W, 8, opaque sideband width carried with each beat.

Ports:
- CLK  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_z  in  W+1 (W=$clog2(MAXZ))  run-time lifting size.
- in_dir  in  1  0 = rotate right (out[j]=in[(j+s) mod z]); 1 = rotate left.
- in_shift  in  NUM_LANES*W  per-lane shift, lane k at [k*W +: W].
- in_data  in  NUM_LANES*MAXZ  lane k at [k*MAXZ +: MAXZ]; only bits [z-1:0] are meaningful.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_LANES*MAXZ  rotated lanes; bits ≥ z are always 0.
- out_tag  out  TAG_W  sideband, aligned with its data.
- out_err  out  NUM_LANES  per-lane illegal-request flag.

Behaviour:
- Reset: rst_n=0 at a CLK edge clears all stage valids, data and tags to 0. out_valid=0, out_data=0, out_tag=0, out_err=0. in_ready=1 from the first cycle after reset.
- Handshake: a beat is accepted when in_valid && in_ready. The pipeline advances when adv = !out_valid || out_ready. in_ready = adv.
- Stall: on stall, all stages hold; data, tag and err are stable while out_valid=1 && !out_ready. Bubbles are not compressed.
- Stage 0 (input register):
  - Mask each lane to its z bits.
  - Normalise: r = dir ? (s==0 ? 0 : z-s) : s.
  - Complementary amount c = z-r.
  - err_k = (z==0) || (z>MAXZ) || (s_k ≥ z).
- Shift stages: NS = ceil(W/ROTATES_PER_CYCLE).
  - Stage i applies levels i*RPC .. i*RPC+RPC-1.
  - Each lane runs two parallel logical barrel shifters: A = data >> r, B = data << c. Shift level n moves by 2^n when bit n of the respective amount is set.
  - Levels ≥ W are pass-through; no logic is generated for them.
- Final merge, in the last shift stage's register:
  - lane_out = (r==0) ? data : ((A | B) & zmask).
  - If err_k, lane_out = 0.
- Latency: LATENCY = 1 + NS cycles accept-to-output when out_ready is held high. Throughput is 1 beat/cycle.
- Boundaries:
  - s=0 → identity.
  - z=MAXZ with r=0 takes the bypass, so no W+1-bit shift is needed.
  - z=1 → identity for s=0; err for s ≥ 1.
- Simultaneous accept and output in the same cycle is legal with no loss.
- Reset mid-stream discards all in-flight beats; nothing is emitted for them.
- Input bits at or above z are ignored; they never leak into the output.

Decomposition:
- Package qc_shift_pkg:
  - localparams/functions: shift_w(MAXZ), num_stages(W, RPC), latency(MAXZ, RPC).
  - typedef of the per-stage control struct {valid, tag, z, zmask-bypass flag, err vector}.
- Sub-module qc_shift_lane (one lane):
  - dual barrel shifters with stage registers and enable-gated hold, plus merge/mask.
  - Instantiated NUM_LANES times.
- Top level owns normalisation, the error check, the control pipeline and the handshake.

Test Plan:
- MAXZ=81, z=8, dir=0, s=3, lane0 data=0x01 → out lane0=0x20 after LATENCY cycles, err=0.
- z=8, dir=1, s=3, data=0x01 → 0x08. Then z=81, dir=0, s=80, data=0x1 → 0x2. Then z=81, s=0, random data → identical data.
- z=8, s=9 on lane2 with legal shifts on the other lanes → out_err=4'b0100, lane2=0, other lanes correct.
- Streaming with out_ready toggled by a 50% random pattern → every beat emitted exactly once in order, tags matching, and out_* stable during stall. Scoreboard is a golden mod-z rotate.
- Data with garbage bits at or above z=5 (data=0xFF…F, s=1) → out=0x1F with all upper bits 0.
- Fill the pipeline, then rst_n=0 for 1 cycle → out_valid=0 next cycle and no stale beat ever appears. A new beat after reset has exact LATENCY.

Source files
------------

// File: rtl/qc_shift_pkg.sv
// Sizing helpers shared by the variable-Z cyclic shifter top and its lanes.
package qc_shift_pkg;

    function automatic int shift_w(input int maxz);
        return (maxz > 1) ? $clog2(maxz) : 1;
    endfunction

    function automatic int num_stages(input int w, input int rpc);
        return (w + rpc - 1) / rpc;
    endfunction

    function automatic int latency(input int maxz, input int rpc);
        return 1 + num_stages(shift_w(maxz), rpc);
    endfunction

endpackage

// File: rtl/qc_shift_lane.sv
// One rotation lane: input register, two pipelined logical barrel shifters
// (right by r, left by c) and a final merge/mask register.
module qc_shift_lane
    import qc_shift_pkg::*;
#(
    parameter int  MAXZ = 384,
    parameter int  RPC  = 2,
    localparam int W    = shift_w(MAXZ),
    localparam int NS   = num_stages(W, RPC)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            en,
    input  logic [MAXZ-1:0] in_data,
    input  logic [MAXZ-1:0] in_zmask,
    input  logic [W-1:0]    in_r,
    input  logic [W-1:0]    in_c,
    input  logic [MAXZ-1:0] fin_zmask,
    input  logic            fin_err,
    output logic [MAXZ-1:0] out_data
);

    logic [MAXZ-1:0] a_reg  [0:NS-1];
    logic [MAXZ-1:0] b_reg  [0:NS-1];
    logic [W-1:0]    r_reg  [0:NS-1];
    logic [W-1:0]    c_reg  [0:NS-1];
    logic [MAXZ-1:0] a_next [0:NS-1];
    logic [MAXZ-1:0] b_next [0:NS-1];
    logic [MAXZ-1:0] out_next;
    logic [MAXZ-1:0] out_reg;

    // Levels at or above W fold away because the (n < W) test is constant per call.
    function automatic logic [MAXZ-1:0] shift_levels(input logic [MAXZ-1:0] d,
                                                     input logic [W-1:0] amt,
                                                     input int lo, input logic left);
        logic [MAXZ-1:0] t;
        t = d;
        for (int n = lo; n < lo + RPC; n++) begin
            if (n < W) begin
                if (amt[n]) t = left ? (t << (1 << n)) : (t >> (1 << n));
            end
        end
        return t;
    endfunction

    for (genvar gi = 0; gi < NS; gi++) begin : g_stage
        assign a_next[gi] = shift_levels(a_reg[gi], r_reg[gi], gi * RPC, 1'b0);
        assign b_next[gi] = shift_levels(b_reg[gi], c_reg[gi], gi * RPC, 1'b1);
    end

    always_comb begin
        out_next = '0;
        if (!fin_err) begin
            if (r_reg[NS-1] == '0) out_next = a_next[NS-1];
            else                   out_next = (a_next[NS-1] | b_next[NS-1]) & fin_zmask;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
                r_reg[i] <= '0;
                c_reg[i] <= '0;
            end
            out_reg <= '0;
        end else if (en) begin
            a_reg[0] <= in_data & in_zmask;
            b_reg[0] <= in_data & in_zmask;
            r_reg[0] <= in_r;
            c_reg[0] <= in_c;
            for (int i = 1; i < NS; i++) begin
                a_reg[i] <= a_next[i-1];
                b_reg[i] <= b_next[i-1];
                r_reg[i] <= r_reg[i-1];
                c_reg[i] <= c_reg[i-1];
            end
            out_reg <= out_next;
        end
    end

    assign out_data = out_reg;

endmodule

// File: rtl/qc_var_z_cyclic_shifter.sv
// Multi-lane pipelined mod-z cyclic shifter for QC-LDPC expansion with
// valid/ready flow control, tag sideband and per-lane illegal-request flags.
module qc_var_z_cyclic_shifter
    import qc_shift_pkg::*;
#(
    parameter int  MAXZ              = 384,
    parameter int  NUM_LANES         = 4,
    parameter int  ROTATES_PER_CYCLE = 2,
    parameter int  TAG_W             = 8,
    localparam int W                 = shift_w(MAXZ),
    localparam int ZW                = W + 1
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ZW-1:0]             in_z,
    input  logic                      in_dir,
    input  logic [NUM_LANES*W-1:0]    in_shift,
    input  logic [NUM_LANES*MAXZ-1:0] in_data,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_LANES*MAXZ-1:0] out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic [NUM_LANES-1:0]      out_err
);

    localparam int NS = num_stages(W, ROTATES_PER_CYCLE);

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [ZW-1:0]        z;
        logic [NUM_LANES-1:0] err;
    } ctl_t;

    ctl_t                 ctl_reg [0:NS];
    ctl_t                 ctl_next;
    logic [NUM_LANES-1:0] err_vec;
    logic [MAXZ-1:0]      in_zmask;
    logic [MAXZ-1:0]      fin_zmask;
    logic                 adv;

    function automatic logic [MAXZ-1:0] zmask_of(input logic [ZW-1:0] z);
        logic [MAXZ-1:0] m;
        m = '0;
        for (int i = 0; i < MAXZ; i++) m[i] = (ZW'(i) < z);
        return m;
    endfunction

    // Whole pipeline moves in lockstep; bubbles travel with the beats.
    assign adv       = !ctl_reg[NS].valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = ctl_reg[NS].valid;
    assign out_tag   = ctl_reg[NS].tag;
    assign out_err   = ctl_reg[NS].err;

    assign in_zmask  = zmask_of(in_z);
    assign fin_zmask = zmask_of(ctl_reg[NS-1].z);
    assign ctl_next  = '{valid: in_valid, tag: in_tag, z: in_z, err: err_vec};

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic [W-1:0] c;

        // Left rotation by s is right rotation by z-s; c only matters when r != 0,
        // where it is at most MAXZ-1 and fits W bits.
        assign s = in_shift[gi*W +: W];
        assign r = !in_dir ? s : ((s == '0) ? '0 : W'(in_z - ZW'(s)));
        assign c = W'(in_z - ZW'(r));
        assign err_vec[gi] = (in_z == '0) || (in_z > ZW'(MAXZ)) || (ZW'(s) >= in_z);

        qc_shift_lane #(
            .MAXZ (MAXZ),
            .RPC  (ROTATES_PER_CYCLE)
        ) u_lane (
            .CLK       (CLK),
            .rst_n     (rst_n),
            .en        (adv),
            .in_data   (in_data[gi*MAXZ +: MAXZ]),
            .in_zmask  (in_zmask),
            .in_r      (r),
            .in_c      (c),
            .fin_zmask (fin_zmask),
            .fin_err   (ctl_reg[NS-1].err[gi]),
            .out_data  (out_data[gi*MAXZ +: MAXZ])
        );
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            for (int i = 0; i <= NS; i++) ctl_reg[i] <= '0;
        end else if (adv) begin
            ctl_reg[0] <= ctl_next;
            for (int i = 1; i <= NS; i++) ctl_reg[i] <= ctl_reg[i-1];
        end
    end

endmodule

// File: tb/tb_qc_var_z_cyclic_shifter.sv
// Table-driven and scoreboarded bench for the variable-Z cyclic shifter (MAXZ=81).
module tb_qc_var_z_cyclic_shifter;

    localparam int MAXZ  = 81;
    localparam int NL    = 4;
    localparam int RPC   = 2;
    localparam int TAG_W = 8;
    localparam int W     = 7;
    localparam int ZW    = W + 1;
    localparam int LAT   = 5;
    localparam int NDIR  = 10;
    localparam int NRND  = 48;

    typedef struct packed {
        logic [ZW-1:0]        z;
        logic                 dir;
        logic [NL*W-1:0]      s;
        logic [NL*MAXZ-1:0]   d;
        logic [TAG_W-1:0]     tag;
        logic [NL*MAXZ-1:0]   exp_d;
        logic [NL-1:0]        exp_err;
    } vec_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [NL*MAXZ-1:0] d;
        logic [NL-1:0]      err;
    } exp_t;

    logic                 CLK = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [ZW-1:0]        in_z = '0;
    logic                 in_dir = 1'b0;
    logic [NL*W-1:0]      in_shift = '0;
    logic [NL*MAXZ-1:0]   in_data = '0;
    logic [TAG_W-1:0]     in_tag = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [NL*MAXZ-1:0]   out_data;
    logic [TAG_W-1:0]     out_tag;
    logic [NL-1:0]        out_err;

    vec_t                 dir_tab [NDIR];
    exp_t                 sb_q [$];
    exp_t                 cur_exp;
    exp_t                 pop_e;
    int                   n_cmp = 0;
    int                   n_bad = 0;
    bit                   rand_ready = 1'b0;
    bit                   held_v = 1'b0;
    logic [NL*MAXZ-1:0]   held_d;
    logic [TAG_W-1:0]     held_t;
    logic [NL-1:0]        held_e;

    qc_var_z_cyclic_shifter #(
        .MAXZ              (MAXZ),
        .NUM_LANES         (NL),
        .ROTATES_PER_CYCLE (RPC),
        .TAG_W             (TAG_W)
    ) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_dir    (in_dir),
        .in_shift  (in_shift),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Golden mod-z rotate, written straight from the index definition.
    function automatic logic [MAXZ-1:0] golden(input logic [MAXZ-1:0] d, input int z,
                                               input bit dir, input int s);
        logic [MAXZ-1:0] o;
        o = '0;
        if (z == 0 || z > MAXZ || s >= z) return o;
        for (int j = 0; j < z; j++) o[j] = dir ? d[(j - s + z) % z] : d[(j + s) % z];
        return o;
    endfunction

    function automatic logic [MAXZ-1:0] rand_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[MAXZ-1:0];
    endfunction

    function automatic vec_t mkv(input int z, input bit dir, input int s0, s1, s2, s3,
                                 input logic [MAXZ-1:0] d0, d1, d2, d3,
                                 input logic [MAXZ-1:0] e0, e1, e2, e3,
                                 input logic [NL-1:0] err, input int tag);
        vec_t v;
        v.z       = ZW'(z);
        v.dir     = dir;
        v.s       = {W'(s3), W'(s2), W'(s1), W'(s0)};
        v.d       = {d3, d2, d1, d0};
        v.tag     = TAG_W'(tag);
        v.exp_d   = {e3, e2, e1, e0};
        v.exp_err = err;
        return v;
    endfunction

    function automatic vec_t mk_rand(input int tag, input bit allow_err);
        vec_t v;
        int   z;
        int   s;
        z     = int'($urandom_range(1, MAXZ));
        v.z   = ZW'(z);
        v.dir = 1'($urandom_range(0, 1));
        v.tag = TAG_W'(tag);
        for (int k = 0; k < NL; k++) begin
            s = allow_err ? int'($urandom_range(0, z + 1)) : int'($urandom_range(0, z - 1));
            if (s > (1 << W) - 1) s = (1 << W) - 1;
            v.s[k*W +: W]             = W'(s);
            v.d[k*MAXZ +: MAXZ]       = rand_word();
            v.exp_d[k*MAXZ +: MAXZ]   = golden(v.d[k*MAXZ +: MAXZ], z, v.dir, s);
            v.exp_err[k]              = (s >= z);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [NL*MAXZ-1:0] got,
                         input logic [NL*MAXZ-1:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Starts and ends at posedge+1; returns after the accepting edge.
    task automatic drive_beat(input vec_t v);
        int guard;
        in_valid = 1'b1;
        in_z     = v.z;
        in_dir   = v.dir;
        in_shift = v.s;
        in_data  = v.d;
        in_tag   = v.tag;
        cur_exp  = '{tag: v.tag, d: v.exp_d, err: v.exp_err};
        guard    = 0;
        @(negedge CLK);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge CLK);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_timed(input vec_t v, input string name);
        int lat;
        drive_beat(v);
        lat = 1;
        @(negedge CLK);
        while (!out_valid && lat < 40) begin
            lat++;
            @(negedge CLK);
        end
        check(name, (NL*MAXZ)'(lat), (NL*MAXZ)'(LAT));
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 2000) begin
            g++;
            @(posedge CLK);
        end
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d beats outstanding required 0", sb_q.size());
        end
    endtask

    always @(negedge CLK) begin
        if (!rst_n) begin
            sb_q.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t ||
                    out_err !== held_e) begin
                    n_bad++;
                    $display("FAIL stall_hold: got valid=%0b tag=%h err=%b required valid=1 tag=%h err=%b",
                             out_valid, out_tag, out_err, held_t, held_e);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: got tag=%h required no beat", out_tag);
                end else begin
                    pop_e = sb_q.pop_front();
                    if (out_data !== pop_e.d || out_tag !== pop_e.tag || out_err !== pop_e.err) begin
                        n_bad++;
                        $display("FAIL beat: got tag=%h err=%b data=%h required tag=%h err=%b data=%h",
                                 out_tag, out_err, out_data, pop_e.tag, pop_e.err, pop_e.d);
                    end else begin
                        $display("beat tag=%h err=%b ok", out_tag, out_err);
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_t = out_tag;
            held_e = out_err;
            if (in_valid && in_ready) sb_q.push_back(cur_exp);
        end
    end

    initial begin
        logic [MAXZ-1:0] ones;
        logic [MAXZ-1:0] one;
        logic [MAXZ-1:0] pat;
        logic [MAXZ-1:0] rw;
        int              nv;

        ones = '1;
        one  = 1;
        pat  = {17'h1_2345, 64'h6789_ABCD_EF01_2345};
        rw   = rand_word();

        dir_tab[0] = mkv(8, 0, 3, 3, 3, 3, one, 0, 0, 0, 'h20, 0, 0, 0, 4'b0000, 'h10);
        dir_tab[1] = mkv(8, 1, 3, 3, 3, 3, one, 'h2, 0, 0, 'h08, 'h10, 0, 0, 4'b0000, 'h11);
        dir_tab[2] = mkv(81, 0, 80, 80, 1, 0, one, one, one, 'h5,
                         'h2, 'h2, one << 80, 'h5, 4'b0000, 'h12);
        dir_tab[3] = mkv(81, 0, 0, 0, 0, 0, rw, ~rw, pat, ones, rw, ~rw, pat, ones, 4'b0000, 'h13);
        dir_tab[4] = mkv(8, 0, 1, 2, 9, 7, one, one, 'hFF, 'h80, 'h80, 'h40, 0, 'h01, 4'b0100, 'h14);
        dir_tab[5] = mkv(5, 0, 1, 1, 1, 1, ones, ones, ones, ones,
                         'h1F, 'h1F, 'h1F, 'h1F, 4'b0000, 'h15);
        dir_tab[6] = mkv(1, 0, 0, 1, 0, 0, ones, ones, ones, ones, one, 0, one, one, 4'b0010, 'h16);
        dir_tab[7] = mkv(81, 1, 0, 80, 0, 0, pat, one, pat, 0, pat, one << 80, pat, 0, 4'b0000, 'h17);
        dir_tab[8] = mkv(0, 0, 0, 0, 0, 0, ones, ones, ones, ones, 0, 0, 0, 0, 4'b1111, 'h18);
        dir_tab[9] = mkv(82, 0, 0, 1, 2, 3, ones, ones, ones, ones, 0, 0, 0, 0, 4'b1111, 'h19);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_out_valid", (NL*MAXZ)'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_tag", (NL*MAXZ)'(out_tag), '0);
        check("rst_out_err", (NL*MAXZ)'(out_err), '0);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        @(negedge CLK);
        check("in_ready_after_rst", (NL*MAXZ)'(in_ready), (NL*MAXZ)'(1));
        @(posedge CLK);
        #1;

        send_timed(dir_tab[0], "latency_first");
        for (int i = 1; i < NDIR; i++) drive_beat(dir_tab[i]);
        wait_drain();

        rand_ready = 1'b1;
        for (int i = 0; i < NRND; i++) begin
            drive_beat(mk_rand(32 + i, (i % 3) == 0));
            repeat ($urandom_range(0, 1)) begin
                @(posedge CLK);
                #1;
            end
        end
        wait_drain();
        rand_ready = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < LAT; i++) drive_beat(mk_rand(160 + i, 1'b0));
        rst_n = 1'b0;
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        @(negedge CLK);
        check("valid_after_midrst", (NL*MAXZ)'(out_valid), '0);
        nv = 0;
        repeat (10) begin
            @(negedge CLK);
            if (out_valid) nv++;
        end
        check("no_stale_beats", (NL*MAXZ)'(nv), '0);
        @(posedge CLK);
        #1;
        send_timed(dir_tab[1], "latency_after_rst");
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
